// File: rtl/rs_param.sv
`default_nettype none
// ============================================================================
// Module   : rs_param
// Brief    : Collapsing, age-ordered reservation station with multi-lane
//            dispatch, broadcast wakeup (with dispatch bypass), oldest-first issue.
// Revision : 1.0
// ============================================================================
module rs_param #(
   parameter int WAYS  = 3,
   parameter int DEPTH = 8,
   parameter int PW    = 5,
   parameter int TAGW  = 4,
   parameter int NWB   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       freeze_front,
   input  logic                       freeze_back,
   output logic                       full_RS,
   output logic [$clog2(DEPTH+1)-1:0] count,
   input  logic [WAYS*PW-1:0]         Pa_in,
   input  logic [WAYS*PW-1:0]         Pb_in,
   input  logic [WAYS*PW-1:0]         Pw_in,
   input  logic [WAYS*TAGW-1:0]       tag_ROB_in,
   input  logic [WAYS-1:0]            valid_issue,
   input  logic [WAYS-1:0]            valid_op,
   input  logic [WAYS-1:0]            valid_Ra,
   input  logic [WAYS-1:0]            valid_Rb,
   input  logic [NWB*PW-1:0]          Pw_Result,
   input  logic [NWB-1:0]             valid_Result,
   output logic [PW-1:0]              Pa_awake,
   output logic [PW-1:0]              Pb_awake,
   output logic [PW-1:0]              Pw_awake,
   output logic [TAGW-1:0]            tag_ROB_awake,
   output logic                       valid_op_awake
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] C_ONE = CW'(1);

   logic            r_valid [DEPTH];
   logic [PW-1:0]   r_pa    [DEPTH];
   logic [PW-1:0]   r_pb    [DEPTH];
   logic [PW-1:0]   r_pw    [DEPTH];
   logic            r_rdya  [DEPTH];
   logic            r_rdyb  [DEPTH];
   logic [TAGW-1:0] r_tag   [DEPTH];
   logic [CW-1:0]   r_count;

   logic [PW-1:0]   r_pa_awake, r_pb_awake, r_pw_awake;
   logic [TAGW-1:0] r_tag_awake;
   logic            r_voa;

   logic            n_valid [DEPTH];
   logic [PW-1:0]   n_pa    [DEPTH];
   logic [PW-1:0]   n_pb    [DEPTH];
   logic [PW-1:0]   n_pw    [DEPTH];
   logic            n_rdya  [DEPTH];
   logic            n_rdyb  [DEPTH];
   logic [TAGW-1:0] n_tag   [DEPTH];

   logic            w_wake_a [DEPTH];
   logic            w_wake_b [DEPTH];
   logic            w_lane_rdya [WAYS];
   logic            w_lane_rdyb [WAYS];
   logic            w_accept [WAYS];
   logic [CW-1:0]   w_pos [WAYS];
   logic [CW-1:0]   w_acc;
   logic [CW-1:0]   w_cnt_post;
   logic            w_found, w_issue_en, w_issued, w_full, w_disp_en;
   logic [IW-1:0]   w_sel;

   assign w_full     = (DEPTH - int'(r_count)) < WAYS;
   assign w_issue_en = !flush && !freeze_back;
   assign w_issued   = w_issue_en && w_found;
   assign w_disp_en  = !flush && !freeze_front && !w_full;
   assign w_cnt_post = r_count - CW'(w_issued);

   // Broadcast match for stored sources and for incoming (bypassed) sources.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_wake_a[i] = 1'b0;
         w_wake_b[i] = 1'b0;
         for (int k = 0; k < NWB; k++) begin
            if (valid_Result[k] && (Pw_Result[k*PW +: PW] == r_pa[i])) w_wake_a[i] = 1'b1;
            if (valid_Result[k] && (Pw_Result[k*PW +: PW] == r_pb[i])) w_wake_b[i] = 1'b1;
         end
      end
      for (int j = 0; j < WAYS; j++) begin
         w_lane_rdya[j] = valid_Ra[j];
         w_lane_rdyb[j] = valid_Rb[j];
         for (int k = 0; k < NWB; k++) begin
            if (valid_Result[k] && (Pw_Result[k*PW +: PW] == Pa_in[j*PW +: PW])) w_lane_rdya[j] = 1'b1;
            if (valid_Result[k] && (Pw_Result[k*PW +: PW] == Pb_in[j*PW +: PW])) w_lane_rdyb[j] = 1'b1;
         end
      end
   end

   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (r_valid[i] && r_rdya[i] && r_rdyb[i]) begin
            w_found = 1'b1;
            w_sel   = IW'(i);
         end
      end
   end

   always_comb begin
      w_acc = '0;
      for (int j = 0; j < WAYS; j++) begin
         w_accept[j] = w_disp_en && valid_issue[j] && valid_op[j];
         w_pos[j]    = w_cnt_post + w_acc;
         if (w_accept[j]) w_acc = w_acc + C_ONE;
      end
   end

   // Collapse over the issued slot first, then append accepted lanes at the tail.
   always_comb begin
      int  src;
      logic shift;
      for (int i = 0; i < DEPTH; i++) begin
         shift = w_issued && (i >= int'(w_sel));
         src   = (shift && (i < DEPTH-1)) ? i + 1 : i;
         n_valid[i] = (shift && (i == DEPTH-1)) ? 1'b0 : r_valid[src];
         n_pa[i]    = r_pa[src];
         n_pb[i]    = r_pb[src];
         n_pw[i]    = r_pw[src];
         n_tag[i]   = r_tag[src];
         n_rdya[i]  = r_rdya[src] | w_wake_a[src];
         n_rdyb[i]  = r_rdyb[src] | w_wake_b[src];
         for (int j = 0; j < WAYS; j++) begin
            if (w_accept[j] && (int'(w_pos[j]) == i)) begin
               n_valid[i] = 1'b1;
               n_pa[i]    = Pa_in[j*PW +: PW];
               n_pb[i]    = Pb_in[j*PW +: PW];
               n_pw[i]    = Pw_in[j*PW +: PW];
               n_tag[i]   = tag_ROB_in[j*TAGW +: TAGW];
               n_rdya[i]  = w_lane_rdya[j];
               n_rdyb[i]  = w_lane_rdyb[j];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_pa[i]    <= '0;
            r_pb[i]    <= '0;
            r_pw[i]    <= '0;
            r_tag[i]   <= '0;
            r_rdya[i]  <= 1'b0;
            r_rdyb[i]  <= 1'b0;
         end
         r_count     <= '0;
         r_pa_awake  <= '0;
         r_pb_awake  <= '0;
         r_pw_awake  <= '0;
         r_tag_awake <= '0;
         r_voa       <= 1'b0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
         r_count <= '0;
         r_voa   <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= n_valid[i];
            r_pa[i]    <= n_pa[i];
            r_pb[i]    <= n_pb[i];
            r_pw[i]    <= n_pw[i];
            r_tag[i]   <= n_tag[i];
            r_rdya[i]  <= n_rdya[i];
            r_rdyb[i]  <= n_rdyb[i];
         end
         r_count <= w_cnt_post + w_acc;
         if (w_issue_en) begin
            r_voa <= w_found;
            if (w_found) begin
               r_pa_awake  <= r_pa[w_sel];
               r_pb_awake  <= r_pb[w_sel];
               r_pw_awake  <= r_pw[w_sel];
               r_tag_awake <= r_tag[w_sel];
            end
         end
      end
   end

   assign full_RS        = w_full;
   assign count          = r_count;
   assign Pa_awake       = r_pa_awake;
   assign Pb_awake       = r_pb_awake;
   assign Pw_awake       = r_pw_awake;
   assign tag_ROB_awake  = r_tag_awake;
   assign valid_op_awake = r_voa;

endmodule
`default_nettype wire

// File: tb/tb_rs_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_param
// Brief    : Scoreboard bench for rs_param (default parameters).
// Revision : 1.0
// ============================================================================
module tb_rs_param;

   localparam int WAYS = 3, DEPTH = 8, PW = 5, TAGW = 4, NWB = 2;

   logic clk = 1'b0, rst = 1'b0, flush = 1'b0, freeze_front = 1'b0, freeze_back = 1'b0;
   logic full_RS;
   logic [3:0] count;
   logic [WAYS*PW-1:0] Pa_in = '0, Pb_in = '0, Pw_in = '0;
   logic [WAYS*TAGW-1:0] tag_ROB_in = '0;
   logic [WAYS-1:0] valid_issue = '0, valid_op = '0, valid_Ra = '0, valid_Rb = '0;
   logic [NWB*PW-1:0] Pw_Result = '0;
   logic [NWB-1:0] valid_Result = '0;
   logic [PW-1:0] Pa_awake, Pb_awake, Pw_awake;
   logic [TAGW-1:0] tag_ROB_awake;
   logic valid_op_awake;

   typedef struct { logic [3:0] tag; logic [4:0] pw; } exp_t;
   exp_t sb[$];
   exp_t e;
   int tests_run = 0, tests_failed = 0;

   always #5 clk = ~clk;

   rs_param #(.WAYS(WAYS), .DEPTH(DEPTH), .PW(PW), .TAGW(TAGW), .NWB(NWB)) dut (
      .clk(clk), .rst(rst), .flush(flush), .freeze_front(freeze_front), .freeze_back(freeze_back),
      .full_RS(full_RS), .count(count), .Pa_in(Pa_in), .Pb_in(Pb_in), .Pw_in(Pw_in),
      .tag_ROB_in(tag_ROB_in), .valid_issue(valid_issue), .valid_op(valid_op),
      .valid_Ra(valid_Ra), .valid_Rb(valid_Rb), .Pw_Result(Pw_Result), .valid_Result(valid_Result),
      .Pa_awake(Pa_awake), .Pb_awake(Pb_awake), .Pw_awake(Pw_awake),
      .tag_ROB_awake(tag_ROB_awake), .valid_op_awake(valid_op_awake));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int j, input logic [4:0] pa, input logic [4:0] pb, input logic [4:0] pw,
                           input logic [3:0] tag, input logic ra, input logic rb);
      Pa_in[j*PW +: PW] = pa;
      Pb_in[j*PW +: PW] = pb;
      Pw_in[j*PW +: PW] = pw;
      tag_ROB_in[j*TAGW +: TAGW] = tag;
      valid_issue[j] = 1'b1;
      valid_op[j]    = 1'b1;
      valid_Ra[j]    = ra;
      valid_Rb[j]    = rb;
   endtask

   task automatic clear_lanes();
      valid_issue = '0; valid_op = '0; valid_Ra = '0; valid_Rb = '0;
      Pa_in = '0; Pb_in = '0; Pw_in = '0; tag_ROB_in = '0;
      valid_Result = '0; Pw_Result = '0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      tick(); tick();
      tests_run++;
      if (count !== 4'd0 || valid_op_awake !== 1'b0 || full_RS !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: count=%0d voa=%b full=%b, expected 0/0/0", count, valid_op_awake, full_RS);
      end
      tests_run++;
      if (tag_ROB_awake !== 4'd0 || Pw_awake !== 5'd0) begin
         tests_failed++;
         $display("FAIL reset_awake: tag=%0d pw=%0d, expected 0/0", tag_ROB_awake, Pw_awake);
      end
      rst = 1'b1;
      tick();
      clear_lanes();
      for (int j = 0; j < 3; j++) set_lane(j, 5'(20 + j), 5'd1, 5'd2, 4'(1 + j), 1'b0, 1'b1);
      tick();
      clear_lanes();
      set_lane(0, 5'd1, 5'd2, 5'd3, 4'd4, 1'b1, 1'b1);
      set_lane(1, 5'd23, 5'd2, 5'd3, 4'd5, 1'b0, 1'b1);
      tick();
      clear_lanes();
      tick();
      tests_run++;
      if (count !== 4'd4 || valid_op_awake !== 1'b1 || tag_ROB_awake !== 4'd4) begin
         tests_failed++;
         $display("FAIL pre_async_reset: count=%0d voa=%b tag=%0d, expected 4/1/4", count, valid_op_awake, tag_ROB_awake);
      end
      #2 rst = 1'b0;
      #1;
      tests_run++;
      if (count !== 4'd0 || valid_op_awake !== 1'b0 || full_RS !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: count=%0d voa=%b full=%b, expected 0/0/0", count, valid_op_awake, full_RS);
      end
      #1 rst = 1'b1;
      tick();
   endtask

   task automatic test_in_order();
      clear_lanes();
      for (int j = 0; j < 3; j++) begin
         set_lane(j, 5'(1 + j), 5'd2, 5'(10 + j), 4'(1 + j), 1'b1, 1'b1);
         sb.push_back('{tag: 4'(1 + j), pw: 5'(10 + j)});
      end
      tick();
      clear_lanes();
      tests_run++;
      if (count !== 4'd3 || valid_op_awake !== 1'b0) begin
         tests_failed++;
         $display("FAIL in_order_written: count=%0d voa=%b, expected 3/0", count, valid_op_awake);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         e = sb.pop_front();
         tests_run++;
         if (valid_op_awake !== 1'b1 || tag_ROB_awake !== e.tag || Pw_awake !== e.pw) begin
            tests_failed++;
            $display("FAIL in_order_issue: voa=%b tag=%0d pw=%0d, expected 1/%0d/%0d",
                     valid_op_awake, tag_ROB_awake, Pw_awake, e.tag, e.pw);
         end
      end
      tests_run++;
      if (count !== 4'd0) begin
         tests_failed++;
         $display("FAIL in_order_drain: count=%0d, expected 0", count);
      end
      tick();
      tests_run++;
      if (valid_op_awake !== 1'b0 || tag_ROB_awake !== 4'd3) begin
         tests_failed++;
         $display("FAIL in_order_idle: voa=%b tag=%0d, expected 0/3 (held)", valid_op_awake, tag_ROB_awake);
      end
   endtask

   task automatic test_back_to_back();
      clear_lanes();
      for (int j = 0; j < 3; j++) begin
         set_lane(j, 5'd1, 5'd1, 5'(j), 4'(1 + j), 1'b1, 1'b1);
         sb.push_back('{tag: 4'(1 + j), pw: 5'(j)});
      end
      tick();
      for (int j = 0; j < 3; j++) begin
         set_lane(j, 5'd1, 5'd1, 5'(3 + j), 4'(4 + j), 1'b1, 1'b1);
         sb.push_back('{tag: 4'(4 + j), pw: 5'(3 + j)});
      end
      tick();
      clear_lanes();
      tests_run++;
      if (count !== 4'd5) begin
         tests_failed++;
         $display("FAIL b2b_count: count=%0d, expected 5", count);
      end
      for (int c = 0; c < 6; c++) begin
         if (c > 0) tick();
         e = sb.pop_front();
         tests_run++;
         if (valid_op_awake !== 1'b1 || tag_ROB_awake !== e.tag || Pw_awake !== e.pw) begin
            tests_failed++;
            $display("FAIL b2b_issue: voa=%b tag=%0d pw=%0d, expected 1/%0d/%0d",
                     valid_op_awake, tag_ROB_awake, Pw_awake, e.tag, e.pw);
         end
      end
      tests_run++;
      if (count !== 4'd0) begin
         tests_failed++;
         $display("FAIL b2b_drain: count=%0d, expected 0", count);
      end
      tick();
   endtask

   task automatic test_age();
      clear_lanes();
      set_lane(0, 5'd7, 5'd1, 5'd2, 4'd5, 1'b0, 1'b1);
      set_lane(1, 5'd8, 5'd1, 5'd3, 4'd6, 1'b1, 1'b1);
      sb.push_back('{tag: 4'd6, pw: 5'd3});
      sb.push_back('{tag: 4'd5, pw: 5'd2});
      tick();
      clear_lanes();
      tick();
      e = sb.pop_front();
      tests_run++;
      if (valid_op_awake !== 1'b1 || tag_ROB_awake !== e.tag) begin
         tests_failed++;
         $display("FAIL age_first: voa=%b tag=%0d, expected 1/%0d", valid_op_awake, tag_ROB_awake, e.tag);
      end
      valid_Result = 2'b01;
      Pw_Result[4:0] = 5'd7;
      tick();
      clear_lanes();
      tests_run++;
      if (valid_op_awake !== 1'b0 || count !== 4'd1) begin
         tests_failed++;
         $display("FAIL age_wake_latency: voa=%b count=%0d, expected 0/1", valid_op_awake, count);
      end
      tick();
      e = sb.pop_front();
      tests_run++;
      if (valid_op_awake !== 1'b1 || tag_ROB_awake !== e.tag || Pw_awake !== e.pw || count !== 4'd0) begin
         tests_failed++;
         $display("FAIL age_second: voa=%b tag=%0d pw=%0d count=%0d, expected 1/%0d/%0d/0",
                  valid_op_awake, tag_ROB_awake, Pw_awake, count, e.tag, e.pw);
      end
   endtask

   task automatic test_bypass();
      clear_lanes();
      set_lane(0, 5'd9, 5'd1, 5'd2, 4'd7, 1'b0, 1'b1);
      set_lane(1, 5'd10, 5'd1, 5'd4, 4'd8, 1'b0, 1'b1);
      valid_Result = 2'b10;
      Pw_Result[9:5] = 5'd9;
      sb.push_back('{tag: 4'd7, pw: 5'd2});
      tick();
      clear_lanes();
      tick();
      e = sb.pop_front();
      tests_run++;
      if (valid_op_awake !== 1'b1 || tag_ROB_awake !== e.tag) begin
         tests_failed++;
         $display("FAIL bypass_issue: voa=%b tag=%0d, expected 1/%0d", valid_op_awake, tag_ROB_awake, e.tag);
      end
      tick();
      tests_run++;
      if (valid_op_awake !== 1'b0 || count !== 4'd1) begin
         tests_failed++;
         $display("FAIL bypass_unmatched: voa=%b count=%0d, expected 0/1", valid_op_awake, count);
      end
      do_flush();
   endtask

   task automatic test_full();
      clear_lanes();
      for (int j = 0; j < 3; j++) set_lane(j, 5'(20 + j), 5'd1, 5'd2, 4'(1 + j), 1'b0, 1'b1);
      tick();
      for (int j = 0; j < 3; j++) set_lane(j, 5'(23 + j), 5'd1, 5'd2, 4'(4 + j), 1'b0, 1'b1);
      tick();
      tests_run++;
      if (count !== 4'd6 || full_RS !== 1'b1) begin
         tests_failed++;
         $display("FAIL full_assert: count=%0d full=%b, expected 6/1", count, full_RS);
      end
      for (int j = 0; j < 3; j++) set_lane(j, 5'd1, 5'd1, 5'd2, 4'(10 + j), 1'b1, 1'b1);
      tick();
      clear_lanes();
      tick();
      tests_run++;
      if (count !== 4'd6 || valid_op_awake !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_ignore: count=%0d voa=%b, expected 6/0", count, valid_op_awake);
      end
      valid_Result = 2'b01;
      Pw_Result[4:0] = 5'd21;
      sb.push_back('{tag: 4'd2, pw: 5'd2});
      tick();
      clear_lanes();
      tick();
      e = sb.pop_front();
      tests_run++;
      if (valid_op_awake !== 1'b1 || tag_ROB_awake !== e.tag || count !== 4'd5 || full_RS !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_release: voa=%b tag=%0d count=%0d full=%b, expected 1/%0d/5/0",
                  valid_op_awake, tag_ROB_awake, count, full_RS, e.tag);
      end
      do_flush();
   endtask

   task automatic test_freeze();
      clear_lanes();
      set_lane(0, 5'd3, 5'd1, 5'd6, 4'd4, 1'b1, 1'b1);
      set_lane(1, 5'd26, 5'd1, 5'd7, 4'd9, 1'b0, 1'b1);
      sb.push_back('{tag: 4'd4, pw: 5'd6});
      tick();
      clear_lanes();
      tick();
      e = sb.pop_front();
      tests_run++;
      if (valid_op_awake !== 1'b1 || tag_ROB_awake !== e.tag || count !== 4'd1) begin
         tests_failed++;
         $display("FAIL freeze_setup: voa=%b tag=%0d count=%0d, expected 1/%0d/1",
                  valid_op_awake, tag_ROB_awake, count, e.tag);
      end
      freeze_back = 1'b1;
      set_lane(0, 5'd2, 5'd2, 5'd8, 4'd11, 1'b1, 1'b1);
      for (int c = 0; c < 3; c++) begin
         tick();
         clear_lanes();
         tests_run++;
         if (valid_op_awake !== 1'b1 || tag_ROB_awake !== 4'd4 || Pa_awake !== 5'd3 || count !== 4'd2) begin
            tests_failed++;
            $display("FAIL freeze_hold: voa=%b tag=%0d pa=%0d count=%0d, expected 1/4/3/2",
                     valid_op_awake, tag_ROB_awake, Pa_awake, count);
         end
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      freeze_back = 1'b0;
      tests_run++;
      if (count !== 4'd0 || valid_op_awake !== 1'b0 || full_RS !== 1'b0) begin
         tests_failed++;
         $display("FAIL freeze_flush: count=%0d voa=%b full=%b, expected 0/0/0", count, valid_op_awake, full_RS);
      end
      tick();
      tests_run++;
      if (valid_op_awake !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_flush_idle: voa=%b, expected 0", valid_op_awake);
      end
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_back_to_back();
      test_age();
      test_bypass();
      test_full();
      test_freeze();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
